fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Frame sequencer for the combinational `RecursiveFFT` datapath. It collects N complex samples from a valid/ready stream into a frame register and drives them onto the FFT input bus. It waits a fixed number of settle cycles for the combinational tree, captures the FFT output bus, and streams the N results out on a second valid/ready port. Frames are processed strictly one at a time: load, settle, unload.

## Interface
Parameters:
- `N`, 4: samples per frame; power of two, ≥2.
- `W`, 15: sample MSB index; sample fields are W+1 bits signed.
- `LAT`, 2: settle cycles between the last load and result capture; ≥1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: controller accepts a sample.
- `in_re`, `in_im` in W+1: signed input sample.
- `in_inv` in 1: transform direction (0 forward, 1 inverse); sampled with sample 0 only.
- `fft_x_re`, `fft_x_im` out N*(W+1): frame register to the FFT; sample k occupies bits [k*(W+1) +: W+1].
- `fft_inv` out 1: latched direction for the current frame.
- `fft_X_re`, `fft_X_im` in N*(W+N): FFT result bus; bin k occupies bits [k*(W+N) +: W+N].
- `out_valid` out 1: result bin valid.
- `out_ready` in 1: downstream accepts the bin.
- `out_re`, `out_im` out W+N: signed result bin.
- `out_idx` out log2(N): bin index of `out_re`/`out_im`.
- `out_last` out 1: high with bin N-1.
- `busy` out 1: high in SETTLE and UNLOAD.

## Operation
- State machine: LOAD → SETTLE → UNLOAD → LOAD.
- **LOAD**
  - `in_ready`=1.
  - On `in_valid & in_ready`, write sample to slot `cnt` and increment `cnt`.
  - At `cnt`=0, also latch `in_inv` into `fft_inv`.
  - Acceptance at `cnt`=N-1 resets `cnt` to 0 and moves to SETTLE, with `scnt` loaded to LAT-1.
- **SETTLE**
  - `in_ready`=0; `scnt` decrements each cycle.
  - At `scnt`=0, capture `fft_X_re`/`fft_X_im` into the result register and move to UNLOAD with `cnt`=0.
- **UNLOAD**
  - `out_valid`=1; `out_re`/`out_im` = result bin `cnt`; `out_idx`=`cnt`; `out_last`=(`cnt`==N-1).
  - On `out_valid & out_ready`, increment `cnt`.
  - Acceptance at `cnt`=N-1 resets `cnt` to 0 and returns to LOAD.
- The frame register and `fft_inv` are held unchanged from the last load through SETTLE, so the FFT inputs are stable while the result is captured.
- No arithmetic in the block; result bits pass through unmodified at W+N width.
- `in_valid` is ignored outside LOAD. No sample is lost, because `in_ready`=0 outside LOAD.
- `out_ready` is ignored outside UNLOAD.
- Output payload (`out_re`, `out_im`, `out_idx`, `out_last`) holds steady while `out_valid & !out_ready`.
- The counter wraps at N-1 back to 0 in both LOAD and UNLOAD.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - state LOAD; `cnt`=0, `scnt`=0.
  - `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0.
  - `out_idx`=0, `out_re`=0, `out_im`=0, `fft_inv`=0.
  - frame and result registers 0.
- Reset mid-frame discards all partial load or unload; the next accepted sample is slot 0.
- Control outputs are registered or decoded from state and `cnt` only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Latency: last input handshake at edge t gives SETTLE during cycles t+1 … t+LAT. Capture happens at edge t+LAT, and `out_valid` rises after that edge.
- Full throughput (valid and ready held high):
  - one frame per N + LAT + N cycles;
  - `in_ready` drops for LAT+N cycles per frame.
- Simultaneous events:
  - The handshake that completes slot N-1 and the state change to SETTLE occur on the same edge.
  - The final output handshake and the return to LOAD occur on the same edge; `in_ready` is 1 in the following cycle.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-UNLOAD → all outputs at reset values within the same cycle; after release, `in_ready`=1 and `cnt`=0.
- **Basic forward frame:** N=4, LAT=2, real FFT attached, samples x[k] = k + i(3-k) in fixed point (1.0 = 1<<BIT_FRAC), `in_inv`=0.
  - Bins out in order idx 0..3: 6+6i, 0+4i, -2+2i, -4+0i.
  - `out_last` only on idx 3.
  - `out_valid` rises exactly 2 cycles after the last input handshake.
- **Input gaps:** `in_valid` toggled 1,0,1,0 → frame register still fills slots 0..3 in order; `fft_inv` equals `in_inv` sampled with slot 0 only (toggle `in_inv` on slots 1–3 and check it is unaffected).
- **Output backpressure:** `out_ready` low for 5 cycles on idx 1 → `out_re`/`out_im`/`out_idx` stable, no bin skipped or duplicated; `in_ready`=0 throughout.
- **Back-to-back frames:** `in_valid` and `out_ready` held 1 across 3 frames, the second with `in_inv`=1 → per frame, 4 inputs, 2 stall cycles, 4 outputs, 10 cycles total; second frame shows `fft_inv`=1 during its SETTLE.
- **LAT=1 variant:** capture occurs on the edge immediately after the last load; results still match the forward-frame expected values.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// fft_frame_ctrl
//
// Frame sequencer wrapped around a purely combinational FFT tree. It gathers N
// complex samples from an input valid/ready stream into a frame register,
// holds that frame on the FFT input bus, waits LAT settle cycles for the tree,
// captures the FFT result bus, and streams the N bins out on an output
// valid/ready stream. Only one frame is in flight: load, settle, unload.
//
// Parameters
//   N    samples per frame (power of two, >= 2)
//   W    sample MSB index; input samples are W+1 bits, result bins W+N bits
//   LAT  settle cycles between the last load and result capture (>= 1)
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   in_re, in_im          input sample (signed, W+1 bits)
//   in_inv                transform direction, taken with sample 0 only
//   fft_x_re, fft_x_im    frame register to the FFT, sample k at [k*(W+1) +: W+1]
//   fft_inv               direction latched for the current frame
//   fft_X_re, fft_X_im    FFT result bus, bin k at [k*(W+N) +: W+N]
//   out_valid / out_ready output handshake
//   out_re, out_im        result bin (signed, W+N bits, passed through as-is)
//   out_idx               bin index of out_re/out_im
//   out_last              high with bin N-1
//   busy                  high while settling or unloading
// -----------------------------------------------------------------------------
module fft_frame_ctrl #(
   parameter int N   = 4,
   parameter int W   = 15,
   parameter int LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W:0]           in_re,
   input  logic [W:0]           in_im,
   input  logic                 in_inv,
   output logic [N*(W+1)-1:0]   fft_x_re,
   output logic [N*(W+1)-1:0]   fft_x_im,
   output logic                 fft_inv,
   input  logic [N*(W+N)-1:0]   fft_X_re,
   input  logic [N*(W+N)-1:0]   fft_X_im,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W+N-1:0]       out_re,
   output logic [W+N-1:0]       out_im,
   output logic [$clog2(N)-1:0] out_idx,
   output logic                 out_last,
   output logic                 busy
);

   localparam int SW = W + 1;            // input sample width
   localparam int RW = W + N;            // result bin width
   localparam int CW = $clog2(N);        // slot / bin counter width
   localparam int TW = $clog2(LAT + 1);  // settle counter width (holds LAT-1)

   localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
   localparam logic [TW-1:0] SCNT_INIT = TW'(LAT - 1);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_UNLOAD = 2'd2
   } state_t;

   state_t          state_reg;
   logic [CW-1:0]   cnt_reg;
   logic [TW-1:0]   scnt_reg;
   logic            inv_reg;

   logic [SW-1:0]   frame_re_reg [N];
   logic [SW-1:0]   frame_im_reg [N];
   logic [RW-1:0]   res_re_reg   [N];
   logic [RW-1:0]   res_im_reg   [N];

   // --------------------------------------------------------------------------
   // Sequencer. The frame register and inv_reg are only written in LOAD, so
   // the FFT inputs stay frozen from the last accepted sample through SETTLE
   // and the captured result belongs to exactly that frame.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_LOAD;
         cnt_reg   <= '0;
         scnt_reg  <= '0;
         inv_reg   <= 1'b0;
         for (int k = 0; k < N; k++) begin
            frame_re_reg[k] <= '0;
            frame_im_reg[k] <= '0;
            res_re_reg[k]   <= '0;
            res_im_reg[k]   <= '0;
         end
      end else begin
         case (state_reg)
            ST_LOAD: begin
               // in_ready is 1 throughout LOAD, so in_valid alone is the handshake
               if (in_valid) begin
                  for (int k = 0; k < N; k++) begin
                     if (cnt_reg == CW'(k)) begin
                        frame_re_reg[k] <= in_re;
                        frame_im_reg[k] <= in_im;
                     end
                  end
                  if (cnt_reg == '0) begin
                     inv_reg <= in_inv;
                  end
                  if (cnt_reg == CNT_LAST) begin
                     cnt_reg   <= '0;
                     scnt_reg  <= SCNT_INIT;
                     state_reg <= ST_SETTLE;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end

            ST_SETTLE: begin
               // scnt starts at LAT-1, so capture lands LAT edges after the
               // last load handshake
               if (scnt_reg == '0) begin
                  for (int k = 0; k < N; k++) begin
                     res_re_reg[k] <= fft_X_re[k*RW +: RW];
                     res_im_reg[k] <= fft_X_im[k*RW +: RW];
                  end
                  cnt_reg   <= '0;
                  state_reg <= ST_UNLOAD;
               end else begin
                  scnt_reg <= scnt_reg - 1'b1;
               end
            end

            ST_UNLOAD: begin
               // out_valid is 1 throughout UNLOAD, so out_ready alone is the handshake
               if (out_ready) begin
                  if (cnt_reg == CNT_LAST) begin
                     cnt_reg   <= '0;
                     state_reg <= ST_LOAD;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end

            default: begin
               state_reg <= ST_LOAD;
               cnt_reg   <= '0;
               scnt_reg  <= '0;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Frame register onto the flat FFT input bus
   // --------------------------------------------------------------------------
   for (genvar gi = 0; gi < N; gi++) begin : g_frame_bus
      assign fft_x_re[gi*SW +: SW] = frame_re_reg[gi];
      assign fft_x_im[gi*SW +: SW] = frame_im_reg[gi];
   end

   assign fft_inv = inv_reg;

   // --------------------------------------------------------------------------
   // Output decode. Everything below depends only on the state register and
   // cnt_reg, never on in_valid or out_ready, so there is no combinational
   // path through the block. The payload is forced to zero outside UNLOAD,
   // and during a stall cnt_reg does not move, so the payload holds.
   // --------------------------------------------------------------------------
   assign in_ready  = (state_reg == ST_LOAD);
   assign busy      = (state_reg != ST_LOAD);
   assign out_valid = (state_reg == ST_UNLOAD);
   assign out_idx   = out_valid ? cnt_reg : '0;
   assign out_last  = out_valid && (cnt_reg == CNT_LAST);
   assign out_re    = out_valid ? res_re_reg[cnt_reg] : '0;
   assign out_im    = out_valid ? res_im_reg[cnt_reg] : '0;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_ctrl
//
// Bench for fft_frame_ctrl with a behavioural 4-point DFT standing in for the
// combinational FFT tree. Two instances: the main one with LAT=2 and a second
// with LAT=1. Directed table and hand-written sequences cover latency, gaps,
// backpressure, reset mid-unload and back-to-back frames; a randomized phase
// is checked by a frame-level scoreboard (collect 4 accepted samples, take
// their DFT, expect those bins in order on the output stream).
// -----------------------------------------------------------------------------
module tb_fft_frame_ctrl;

   localparam int N        = 4;
   localparam int W        = 15;
   localparam int LAT      = 2;
   localparam int SW       = W + 1;
   localparam int RW       = W + N;
   localparam int BIT_FRAC = 8;
   localparam int ONE      = 1 << BIT_FRAC;

   typedef struct {
      int in_re;
      int in_im;
      int ex_idx;
      int ex_re;
      int ex_im;
      bit ex_last;
   } vec_t;

   int vectors     = 0;
   int miscompares = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   // main DUT (LAT=2)
   logic            in_valid, in_ready, in_inv, fft_inv;
   logic [SW-1:0]   in_re, in_im;
   logic [N*SW-1:0] fft_x_re, fft_x_im;
   logic [N*RW-1:0] fx_re, fx_im;
   logic            out_valid, out_ready, out_last, busy;
   logic [RW-1:0]   out_re, out_im;
   logic [1:0]      out_idx;

   // second DUT (LAT=1)
   logic            b_in_valid, b_in_ready, b_in_inv, b_fft_inv;
   logic [SW-1:0]   b_in_re, b_in_im;
   logic [N*SW-1:0] b_fft_x_re, b_fft_x_im;
   logic [N*RW-1:0] b_fx_re, b_fx_im;
   logic            b_out_valid, b_out_ready, b_out_last, b_busy;
   logic [RW-1:0]   b_out_re, b_out_im;
   logic [1:0]      b_out_idx;

   fft_frame_ctrl #(.N(N), .W(W), .LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_re(in_re), .in_im(in_im), .in_inv(in_inv),
      .fft_x_re(fft_x_re), .fft_x_im(fft_x_im), .fft_inv(fft_inv),
      .fft_X_re(fx_re), .fft_X_im(fx_im),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
      .out_last(out_last), .busy(busy)
   );

   fft_frame_ctrl #(.N(N), .W(W), .LAT(1)) dut_lat1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_re(b_in_re), .in_im(b_in_im), .in_inv(b_in_inv),
      .fft_x_re(b_fft_x_re), .fft_x_im(b_fft_x_im), .fft_inv(b_fft_inv),
      .fft_X_re(b_fx_re), .fft_X_im(b_fx_im),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_re(b_out_re), .out_im(b_out_im), .out_idx(b_out_idx),
      .out_last(b_out_last), .busy(b_busy)
   );

   // Unscaled 4-point DFT, X[k] = sum x[n] * w^(n*k), w = -i forward, +i inverse.
   // Rotation by a power of i is exact, so no rounding enters the reference.
   function automatic int dft_bin(input int xr[N], input int xi[N], input bit inv,
                                  input int k, input bit want_im);
      int sr, si, a, b, t;
      sr = 0;
      si = 0;
      for (int n = 0; n < N; n++) begin
         a = xr[n];
         b = xi[n];
         for (int p = 0; p < (n * k) % 4; p++) begin
            t = a;
            if (inv) begin a = -b; b = t;  end
            else     begin a = b;  b = -t; end
         end
         sr += a;
         si += b;
      end
      return want_im ? si : sr;
   endfunction

   // combinational FFT models on each DUT's frame bus
   always_comb begin
      int ar[N];
      int ai[N];
      ar = '{default: 0};
      ai = '{default: 0};
      fx_re = '0;
      fx_im = '0;
      for (int n = 0; n < N; n++) begin
         ar[n] = int'($signed(fft_x_re[n*SW +: SW]));
         ai[n] = int'($signed(fft_x_im[n*SW +: SW]));
      end
      for (int k = 0; k < N; k++) begin
         fx_re[k*RW +: RW] = RW'(dft_bin(ar, ai, fft_inv, k, 1'b0));
         fx_im[k*RW +: RW] = RW'(dft_bin(ar, ai, fft_inv, k, 1'b1));
      end
   end

   always_comb begin
      int ar[N];
      int ai[N];
      ar = '{default: 0};
      ai = '{default: 0};
      b_fx_re = '0;
      b_fx_im = '0;
      for (int n = 0; n < N; n++) begin
         ar[n] = int'($signed(b_fft_x_re[n*SW +: SW]));
         ai[n] = int'($signed(b_fft_x_im[n*SW +: SW]));
      end
      for (int k = 0; k < N; k++) begin
         b_fx_re[k*RW +: RW] = RW'(dft_bin(ar, ai, b_fft_inv, k, 1'b0));
         b_fx_im[k*RW +: RW] = RW'(dft_bin(ar, ai, b_fft_inv, k, 1'b1));
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- helpers
   int fr[N];
   int fi[N];

   task automatic new_frame();
      logic [SW-1:0] v;
      for (int k = 0; k < N; k++) begin
         v = SW'($urandom);
         fr[k] = int'($signed(v));
         v = SW'($urandom);
         fi[k] = int'($signed(v));
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input int re, input int im, input bit inv, input string nm);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_re    = SW'(re);
      in_im    = SW'(im);
      in_inv   = inv;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!ok) chk({nm, "_send_timeout"}, 0, 1);
   endtask

   // Sample 0 carries inv0; slots 1..N-1 carry the opposite value, which must
   // not reach fft_inv.
   task automatic send_frame(input bit inv0, input bit gaps, input string nm);
      for (int k = 0; k < N; k++) begin
         send(fr[k], fi[k], (k == 0) ? inv0 : !inv0, nm);
         if (gaps && k < N - 1) begin @(posedge clk); #1; end
      end
   endtask

   task automatic recv_chk(input int ex_idx, input int ex_re, input int ex_im,
                           input bit ex_last, input string nm);
      bit ok;
      ok = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         if (out_valid) ok = 1'b1;
      end
      chk({nm, "_out_valid"}, ok, 1);
      if (ok) begin
         chk({nm, "_idx"},  out_idx, ex_idx);
         chk({nm, "_re"},   $signed(out_re), ex_re);
         chk({nm, "_im"},   $signed(out_im), ex_im);
         chk({nm, "_last"}, out_last, ex_last);
         chk({nm, "_in_ready_low"}, in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic recv_frame(input bit inv, input string nm);
      for (int k = 0; k < N; k++)
         recv_chk(k, dft_bin(fr, fi, inv, k, 1'b0), dft_bin(fr, fi, inv, k, 1'b1),
                  k == N - 1, nm);
   endtask

   // ------------------------------------------------------------- scoreboard
   bit         sb_on = 1'b0;
   int         cur_re[$];
   int         cur_im[$];
   bit         cur_inv;
   bit         last_inv;
   int         exp_re[$];
   int         exp_im[$];
   int         out_pos    = 0;
   int         frames_out = 0;
   bit         prev_stall = 1'b0;
   logic [RW-1:0] prev_re;
   logic [1:0]    prev_idx;
   int         mr[N];
   int         mi[N];

   initial begin
      int er, ei;
      forever begin
         @(negedge clk);
         if (sb_on && rst_n) begin
            if (busy && !out_valid) chk("sb_settle_inv", fft_inv, last_inv);
            if (busy) chk("sb_in_ready_busy", in_ready, 0);
            if (prev_stall) begin
               chk("sb_hold_re",  out_re,  prev_re);
               chk("sb_hold_idx", out_idx, prev_idx);
            end
            prev_stall = out_valid && !out_ready;
            prev_re    = out_re;
            prev_idx   = out_idx;

            if (in_valid && in_ready) begin
               cur_re.push_back(int'($signed(in_re)));
               cur_im.push_back(int'($signed(in_im)));
               if (cur_re.size() == 1) cur_inv = in_inv;
               if (cur_re.size() == N) begin
                  for (int k = 0; k < N; k++) begin
                     mr[k] = cur_re[k];
                     mi[k] = cur_im[k];
                  end
                  for (int k = 0; k < N; k++) begin
                     exp_re.push_back(dft_bin(mr, mi, cur_inv, k, 1'b0));
                     exp_im.push_back(dft_bin(mr, mi, cur_inv, k, 1'b1));
                  end
                  last_inv = cur_inv;
                  cur_re.delete();
                  cur_im.delete();
               end
            end

            if (out_valid && out_ready) begin
               if (exp_re.size() == 0) begin
                  chk("sb_spurious_out", 1, 0);
               end else begin
                  er = exp_re.pop_front();
                  ei = exp_im.pop_front();
                  chk("sb_re",   $signed(out_re), er);
                  chk("sb_im",   $signed(out_im), ei);
                  chk("sb_idx",  out_idx, out_pos);
                  chk("sb_last", out_last, out_pos == N - 1);
                  out_pos = (out_pos + 1) % N;
                  if (out_pos == 0) frames_out++;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------ main
   vec_t tbl[N];

   initial begin
      in_valid = 0; in_re = '0; in_im = '0; in_inv = 0; out_ready = 0;
      b_in_valid = 0; b_in_re = '0; b_in_im = '0; b_in_inv = 0; b_out_ready = 0;

      // x[k] = k + i(3-k); DFT = 6+6i, 0+4i, -2+2i, -4+0i
      tbl[0] = '{0 * ONE, 3 * ONE, 0,  6 * ONE, 6 * ONE, 1'b0};
      tbl[1] = '{1 * ONE, 2 * ONE, 1,  0 * ONE, 4 * ONE, 1'b0};
      tbl[2] = '{2 * ONE, 1 * ONE, 2, -2 * ONE, 2 * ONE, 1'b0};
      tbl[3] = '{3 * ONE, 0 * ONE, 3, -4 * ONE, 0 * ONE, 1'b1};

      // reset values
      #2;
      chk("rst_in_ready",  in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last",  out_last, 0);
      chk("rst_busy",      busy, 0);
      chk("rst_out_idx",   out_idx, 0);
      chk("rst_out_re",    out_re, 0);
      chk("rst_fft_inv",   fft_inv, 0);
      chk("rst_frame",     (fft_x_re == '0) && (fft_x_im == '0), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // forward frame from the table, latency then bins in order
      for (int k = 0; k < N; k++) send(tbl[k].in_re, tbl[k].in_im, 1'b0, "fwd");
      for (int d = 0; d < 3; d++) begin
         @(negedge clk);
         chk("fwd_lat_out_valid", out_valid, d == 2);
         chk("fwd_lat_busy", busy, 1);
      end
      @(posedge clk); #1;
      for (int k = 0; k < N; k++)
         recv_chk(tbl[k].ex_idx, tbl[k].ex_re, tbl[k].ex_im, tbl[k].ex_last, "fwd");

      // input gaps, in_inv only taken with slot 0
      new_frame();
      send_frame(1'b1, 1'b1, "gap");
      @(negedge clk);
      chk("gap_fft_inv", fft_inv, 1);
      chk("gap_busy", busy, 1);
      for (int k = 0; k < N; k++) begin
         chk("gap_slot_re", $signed(fft_x_re[k*SW +: SW]), fr[k]);
         chk("gap_slot_im", $signed(fft_x_im[k*SW +: SW]), fi[k]);
      end
      @(posedge clk); #1;
      recv_frame(1'b1, "gap");

      // output backpressure on idx 1
      new_frame();
      send_frame(1'b0, 1'b0, "bp");
      recv_chk(0, dft_bin(fr, fi, 1'b0, 0, 1'b0), dft_bin(fr, fi, 1'b0, 0, 1'b1), 1'b0, "bp");
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_stall_valid", out_valid, 1);
         chk("bp_stall_idx",   out_idx, 1);
         chk("bp_stall_re",    $signed(out_re), dft_bin(fr, fi, 1'b0, 1, 1'b0));
         chk("bp_stall_im",    $signed(out_im), dft_bin(fr, fi, 1'b0, 1, 1'b1));
         chk("bp_stall_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      for (int k = 1; k < N; k++)
         recv_chk(k, dft_bin(fr, fi, 1'b0, k, 1'b0), dft_bin(fr, fi, 1'b0, k, 1'b1),
                  k == N - 1, "bp");

      // reset mid-unload
      new_frame();
      send_frame(1'b1, 1'b0, "mid");
      recv_chk(0, dft_bin(fr, fi, 1'b1, 0, 1'b0), dft_bin(fr, fi, 1'b1, 0, 1'b1), 1'b0, "mid");
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready",  in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_last",  out_last, 0);
      chk("mid_rst_busy",      busy, 0);
      chk("mid_rst_out_idx",   out_idx, 0);
      chk("mid_rst_out_re",    out_re, 0);
      chk("mid_rst_out_im",    out_im, 0);
      chk("mid_rst_fft_inv",   fft_inv, 0);
      chk("mid_rst_frame",     (fft_x_re == '0) && (fft_x_im == '0), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      new_frame();
      send_frame(1'b0, 1'b0, "post_rst");
      recv_frame(1'b0, "post_rst");

      // back-to-back frames, 10-cycle period, second frame inverse
      sb_on     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         in_re  = SW'($urandom);
         in_im  = SW'($urandom);
         in_inv = (c / 10 == 1);
         @(negedge clk);
         chk("b2b_in_ready",  in_ready, (c % 10) < 4);
         chk("b2b_out_valid", out_valid, (c % 10) >= 6);
         if ((c % 10) == 4 || (c % 10) == 5)
            chk("b2b_settle_inv", fft_inv, c / 10 == 1);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // randomized traffic against the scoreboard
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom % 3) != 0;
         in_re     = SW'($urandom);
         in_im     = SW'($urandom);
         in_inv    = $urandom % 2;
         out_ready = ($urandom % 4) != 0;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (20) begin @(posedge clk); #1; end
      out_ready = 1'b0;
      @(negedge clk);
      chk("rand_drain_pending_bins", exp_re.size(), 0);
      chk("rand_frames_out_nonzero", frames_out > 10, 1);
      sb_on = 1'b0;
      @(posedge clk); #1;

      // LAT=1 instance: capture on the edge right after the last load
      for (int k = 0; k < N; k++) begin
         b_in_valid = 1'b1;
         b_in_re    = SW'(tbl[k].in_re);
         b_in_im    = SW'(tbl[k].in_im);
         b_in_inv   = 1'b0;
         @(negedge clk);
         chk("lat1_in_ready", b_in_ready, 1);
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0;
      @(negedge clk);
      chk("lat1_settle_valid", b_out_valid, 0);
      chk("lat1_settle_busy",  b_busy, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("lat1_capture_valid", b_out_valid, 1);
      @(posedge clk); #1;
      b_out_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         chk("lat1_valid", b_out_valid, 1);
         chk("lat1_idx",   b_out_idx, tbl[k].ex_idx);
         chk("lat1_re",    $signed(b_out_re), tbl[k].ex_re);
         chk("lat1_im",    $signed(b_out_im), tbl[k].ex_im);
         chk("lat1_last",  b_out_last, tbl[k].ex_last);
         @(posedge clk); #1;
      end
      b_out_ready = 1'b0;
      @(negedge clk);
      chk("lat1_back_to_load", b_in_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
